md_unit: RTL and testbench

- Multiply/divide responder for the five-stage pipeline.
- The EX stage issues mult/multu/div/divu/mthi/mtlo operations with a single-cycle start pulse.
- The unit computes over a fixed multi-cycle latency, holds busy while working, and exposes the architectural HI/LO registers.
- The hazard unit stalls mfhi/mflo and further MD instructions using busy and start.

---
 rtl/md_unit.sv | 130 +++++++++++++
 tb/tb_md_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit holding architectural HI/LO
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_wr;

    logic        accept;
    logic        div_zero;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] sdiv_q;
    logic [31:0] sdiv_r;
    logic [31:0] udiv_q;
    logic [31:0] udiv_r;

    // Issues arriving while busy are dropped; op codes 0 and 7 are no-ops.
    assign accept   = start && !busy && (op >= OP_MULT) && (op <= OP_MTLO);
    assign div_zero = (B == 32'd0);

    // Sign-extending both operands to 64 bits makes the low 64 bits of the
    // unsigned product equal to the signed product.
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};

    // Signed division on magnitudes, then sign fix-up; the most-negative
    // overflow case falls out naturally as 0x80000000 rem 0.
    always_comb begin
        abs_a  = A[31] ? (~A + 32'd1) : A;
        abs_b  = B[31] ? (~B + 32'd1) : B;
        mag_q  = 32'd0;
        mag_r  = 32'd0;
        udiv_q = 32'd0;
        udiv_r = 32'd0;
        if (!div_zero) begin
            mag_q  = abs_a / abs_b;
            mag_r  = abs_a % abs_b;
            udiv_q = A / B;
            udiv_r = A % B;
        end
        sdiv_q = (A[31] ^ B[31]) ? (~mag_q + 32'd1) : mag_q;
        sdiv_r = A[31] ? (~mag_r + 32'd1) : mag_r;
    end

    // Issue, latency countdown and HI/LO commit; busy mirrors counter != 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 4'd0;
            busy    <= 1'b0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else if (accept) begin
            unique case (op)
                OP_MULT: begin
                    pend_hi <= prod_s[63:32];
                    pend_lo <= prod_s[31:0];
                    pend_wr <= 1'b1;
                    cnt     <= MULT_LOAD;
                    busy    <= 1'b1;
                end
                OP_MULTU: begin
                    pend_hi <= prod_u[63:32];
                    pend_lo <= prod_u[31:0];
                    pend_wr <= 1'b1;
                    cnt     <= MULT_LOAD;
                    busy    <= 1'b1;
                end
                OP_DIV: begin
                    pend_hi <= sdiv_r;
                    pend_lo <= sdiv_q;
                    pend_wr <= !div_zero;
                    cnt     <= DIV_LOAD;
                    busy    <= 1'b1;
                end
                OP_DIVU: begin
                    pend_hi <= udiv_r;
                    pend_lo <= udiv_q;
                    pend_wr <= !div_zero;
                    cnt     <= DIV_LOAD;
                    busy    <= 1'b1;
                end
                OP_MTHI: HI <= A;
                OP_MTLO: LO <= A;
                default: ;
            endcase
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                busy    <= 1'b0;
                pend_wr <= 1'b0;
                if (pend_wr) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit with a reference arithmetic model
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: HI/LO outcome of one accepted op, from the arithmetic rules.
    task automatic model_issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      p, sa, sb, q, r;
        logic [63:0] pu, uq, ur;
        e.old_hi = model_hi;
        e.old_lo = model_lo;
        e.hi     = model_hi;
        e.lo     = model_lo;
        e.cycles = 0;
        case (o)
            3'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                e.hi = p[63:32]; e.lo = p[31:0]; e.cycles = 5;
            end
            3'd2: begin
                pu = {32'd0, a} * {32'd0, b};
                e.hi = pu[63:32]; e.lo = pu[31:0]; e.cycles = 5;
            end
            3'd3: begin
                e.cycles = 10;
                if (b != 0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q = sa / sb;
                    r = sa % sb;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end
            end
            3'd4: begin
                e.cycles = 10;
                if (b != 0) begin
                    uq = {32'd0, a} / {32'd0, b};
                    ur = {32'd0, a} % {32'd0, b};
                    e.lo = uq[31:0]; e.hi = ur[31:0];
                end
            end
            3'd5: e.hi = a;
            3'd6: e.lo = a;
            default: ;
        endcase
        if (o >= 3'd1 && o <= 3'd6) begin
            exp_q.push_back(e);
            model_hi = e.hi;
            model_lo = e.lo;
        end
    endtask

    // Called at a negedge; drives one start pulse and returns one negedge later.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_accept);
        if (expect_accept) model_issue(o, a, b);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: detects accepted issues, times the busy window, compares HI/LO.
    initial begin
        exp_t cur;
        bit   acc = 0;
        bit   pending = 0;
        int   run = 0;
        forever begin
            @(posedge clk);
            acc = 0;
            if (reset) begin
                pending = 0;
                run = 0;
            end else if (start && !busy && op >= 3'd1 && op <= 3'd6) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_accept", {29'd0, op}, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    acc = 1;
                end
            end
            @(negedge clk);
            if (acc) begin
                if (cur.cycles == 0) begin
                    check("mt_hi", HI, cur.hi);
                    check("mt_lo", LO, cur.lo);
                    check("mt_no_busy", {31'd0, busy}, 32'd0);
                end else begin
                    check("busy_rise", {31'd0, busy}, 32'd1);
                    pending = 1;
                    run = 1;
                end
            end else if (pending) begin
                if (busy) begin
                    run++;
                    check("hold_hi", HI, cur.old_hi);
                    check("hold_lo", LO, cur.old_lo);
                    if (run > cur.cycles + 5) begin
                        check("busy_stuck", run, cur.cycles);
                        pending = 0;
                    end
                end else begin
                    check("busy_len", run, cur.cycles);
                    check("res_hi", HI, cur.hi);
                    check("res_lo", LO, cur.lo);
                    pending = 0;
                end
            end else begin
                check("spurious_busy", {31'd0, busy}, 32'd0);
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);

        issue(3'd1, 32'hFFFFFFFE, 32'd3, 1);
        wait_idle();
        check("plan_mult_hi", HI, 32'hFFFFFFFF);
        check("plan_mult_lo", LO, 32'hFFFFFFFA);

        issue(3'd2, 32'hFFFFFFFF, 32'd2, 1);
        wait_idle();
        check("plan_multu_hi", HI, 32'h00000001);
        check("plan_multu_lo", LO, 32'hFFFFFFFE);
        issue(3'd1, 32'hFFFFFFFF, 32'd2, 1);
        wait_idle();
        check("plan_mults_hi", HI, 32'hFFFFFFFF);
        check("plan_mults_lo", LO, 32'hFFFFFFFE);

        issue(3'd3, 32'hFFFFFFF9, 32'd2, 1);
        wait_idle();
        check("plan_div_lo", LO, 32'hFFFFFFFD);
        check("plan_div_hi", HI, 32'hFFFFFFFF);
        issue(3'd4, 32'd7, 32'd2, 1);
        wait_idle();
        check("plan_divu_lo", LO, 32'd3);
        check("plan_divu_hi", HI, 32'd1);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1);
        wait_idle();
        check("plan_ovf_lo", LO, 32'h80000000);
        check("plan_ovf_hi", HI, 32'd0);

        issue(3'd5, 32'h11111111, 32'd0, 1);
        check("plan_mthi", HI, 32'h11111111);
        issue(3'd6, 32'h22222222, 32'd0, 1);
        check("plan_mtlo", LO, 32'h22222222);
        issue(3'd4, 32'd5, 32'd0, 1);
        wait_idle();
        check("plan_dz_hi", HI, 32'h11111111);
        check("plan_dz_lo", LO, 32'h22222222);

        // Issue while busy is ignored; then back-to-back issue on busy fall.
        issue(3'd3, 32'd100, 32'd7, 1);
        repeat (2) @(negedge clk);
        issue(3'd5, 32'hDEADBEEF, 32'd0, 0);
        wait_idle();
        check("plan_ignored_hi", HI, 32'd2);
        check("plan_ignored_lo", LO, 32'd14);
        issue(3'd1, 32'd6, 32'd7, 1);
        wait_idle();
        check("plan_b2b_lo", LO, 32'd42);

        // Reset in busy cycle 4 of a mult discards the pending result.
        issue(3'd2, 32'h12345678, 32'h9ABCDEF0, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_hi = 32'd0;
        model_lo = 32'd0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        repeat (8) @(negedge clk);
        check("midrst_late_hi", HI, 32'd0);
        check("midrst_late_lo", LO, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: ra = 32'h80000000;
                1: ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(ro, ra, rb, 1);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
